// File: rtl/hardwired_control_unit.sv
// Hardwired fetch/decode/execute sequencer driving every ALUSystem control input.
// Ports: Clock/Reset, IR_Out and ALU_FlagOut in; RF, ARF, ALU, IR, memory, mux selects and Halted out.
module hardwired_control_unit (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] IR_Out,
   input  logic [3:0]  ALU_FlagOut,
   output logic [2:0]  RF_O1Sel,
   output logic [2:0]  RF_O2Sel,
   output logic [1:0]  RF_FunSel,
   output logic [3:0]  RF_RSel,
   output logic [3:0]  RF_TSel,
   output logic [3:0]  ALU_FunSel,
   output logic [1:0]  ARF_OutASel,
   output logic [1:0]  ARF_OutBSel,
   output logic [1:0]  ARF_FunSel,
   output logic [3:0]  ARF_RSel,
   output logic        IR_LH,
   output logic        IR_Enable,
   output logic [1:0]  IR_FunSel,
   output logic        Mem_WR,
   output logic        Mem_CS,
   output logic [1:0]  MuxASel,
   output logic [1:0]  MuxBSel,
   output logic        MuxCSel,
   output logic        Halted
);

   typedef enum logic [3:0] {
      S_INIT,
      S_F0,
      S_F1,
      S_F2,
      S_DEC,
      S_E0,
      S_E1,
      S_E2,
      S_HALT
   } state_t;

   localparam logic [3:0] OP_LDI = 4'h0;
   localparam logic [3:0] OP_LD  = 4'h1;
   localparam logic [3:0] OP_ST  = 4'h2;
   localparam logic [3:0] OP_MOV = 4'h3;
   localparam logic [3:0] OP_INC = 4'h9;
   localparam logic [3:0] OP_DEC = 4'hA;
   localparam logic [3:0] OP_BRA = 4'hB;
   localparam logic [3:0] OP_BEQ = 4'hC;
   localparam logic [3:0] OP_HLT = 4'hF;

   state_t     state;
   state_t     state_nx;
   logic       zlat;
   logic       zlat_we;

   logic [3:0] opc;
   logic [1:0] rd;
   logic [1:0] rs;
   logic [2:0] sel_rd;
   logic [2:0] sel_rs;
   logic [3:0] rd_oh;
   logic [3:0] alu_code;
   logic       is_alu;
   logic       is_long;

   // Immediate/address bits travel through the datapath muxes and only Z
   // matters to sequencing; fold the rest into a sink.
   logic       unused_bits;
   assign unused_bits = ^{IR_Out[7:0], ALU_FlagOut[2:0]};

   assign opc    = IR_Out[15:12];
   assign rd     = IR_Out[11:10];
   assign rs     = IR_Out[9:8];
   assign sel_rd = {1'b1, rd};
   assign sel_rs = {1'b1, rs};

   always_comb begin
      rd_oh = 4'b1000;
      unique case (rd)
         2'b00: rd_oh = 4'b1000;
         2'b01: rd_oh = 4'b0100;
         2'b10: rd_oh = 4'b0010;
         2'b11: rd_oh = 4'b0001;
         default: rd_oh = 4'b1000;
      endcase
   end

   always_comb begin
      alu_code = 4'b0000;
      is_alu   = 1'b1;
      case (opc)
         4'h4: alu_code = 4'b0100;
         4'h5: alu_code = 4'b0101;
         4'h6: alu_code = 4'b0111;
         4'h7: alu_code = 4'b1000;
         4'h8: alu_code = 4'b1010;
         default: is_alu = 1'b0;
      endcase
   end

   // Ops that need at least one execute step past E0.
   assign is_long = (opc == OP_LD) || (opc == OP_ST) ||
                    (opc == OP_MOV) || is_alu;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state <= S_INIT;
         zlat  <= 1'b0;
      end else begin
         state <= state_nx;
         if (zlat_we) begin
            zlat <= ALU_FlagOut[3];
         end
      end
   end

   always_comb begin
      state_nx    = state;
      zlat_we     = 1'b0;
      RF_O1Sel    = 3'b100;
      RF_O2Sel    = 3'b100;
      RF_FunSel   = 2'b01;
      RF_RSel     = 4'b0000;
      RF_TSel     = 4'b0000;
      ALU_FunSel  = 4'b0000;
      ARF_OutASel = 2'b11;
      ARF_OutBSel = 2'b11;
      ARF_FunSel  = 2'b01;
      ARF_RSel    = 4'b0000;
      IR_LH       = 1'b0;
      IR_Enable   = 1'b0;
      IR_FunSel   = 2'b01;
      Mem_WR      = 1'b0;
      Mem_CS      = 1'b1;
      MuxASel     = 2'b00;
      MuxBSel     = 2'b00;
      MuxCSel     = 1'b0;
      Halted      = 1'b0;

      case (state)
         S_INIT: state_nx = S_F0;
         S_F0:   state_nx = S_F1;
         S_F1:   state_nx = S_F2;
         S_F2:   state_nx = S_DEC;
         S_DEC:  state_nx = (opc == OP_HLT) ? S_HALT : S_E0;
         S_E0:   state_nx = is_long ? S_E1 : S_F0;
         S_E1:   state_nx = (opc == OP_LD) ? S_F0 : S_E2;
         S_E2:   state_nx = S_F0;
         S_HALT: state_nx = S_HALT;
         default: state_nx = S_INIT;
      endcase

      // Reset forces idle outputs regardless of where the sequence was.
      if (!Reset) begin
         case (state)
            S_INIT: begin
               ARF_FunSel = 2'b00;
               ARF_RSel   = 4'b1000;
            end
            S_F0: begin
               ARF_OutBSel = 2'b11;
            end
            S_F1, S_F2: begin
               Mem_CS     = 1'b0;
               IR_Enable  = 1'b1;
               IR_LH      = (state == S_F2);
               ARF_FunSel = 2'b10;
               ARF_RSel   = 4'b1000;
            end
            S_E0: begin
               case (opc)
                  OP_LDI: begin
                     MuxASel = 2'b10;
                     RF_RSel = rd_oh;
                  end
                  OP_LD: begin
                     MuxBSel     = 2'b10;
                     ARF_RSel    = 4'b0100;
                     ARF_OutBSel = 2'b00;
                  end
                  OP_ST: begin
                     MuxBSel     = 2'b10;
                     ARF_RSel    = 4'b0100;
                     ARF_OutBSel = 2'b00;
                     RF_O1Sel    = sel_rd;
                  end
                  OP_MOV: begin
                     RF_O1Sel = sel_rs;
                  end
                  OP_INC: begin
                     RF_FunSel = 2'b11;
                     RF_RSel   = rd_oh;
                  end
                  OP_DEC: begin
                     RF_FunSel = 2'b10;
                     RF_RSel   = rd_oh;
                  end
                  OP_BRA: begin
                     MuxBSel  = 2'b10;
                     ARF_RSel = 4'b1000;
                  end
                  OP_BEQ: begin
                     if (zlat) begin
                        MuxBSel  = 2'b10;
                        ARF_RSel = 4'b1000;
                     end
                  end
                  default: begin
                     if (is_alu) begin
                        RF_O1Sel = sel_rd;
                        RF_O2Sel = sel_rs;
                     end
                  end
               endcase
            end
            S_E1: begin
               case (opc)
                  OP_LD: begin
                     ARF_OutBSel = 2'b00;
                     Mem_CS      = 1'b0;
                     MuxASel     = 2'b01;
                     RF_RSel     = rd_oh;
                  end
                  OP_ST: begin
                     ARF_OutBSel = 2'b00;
                     RF_O1Sel    = sel_rd;
                  end
                  OP_MOV: begin
                     RF_O1Sel = sel_rs;
                  end
                  default: begin
                     if (is_alu) begin
                        RF_O1Sel   = sel_rd;
                        RF_O2Sel   = sel_rs;
                        ALU_FunSel = alu_code;
                     end
                  end
               endcase
            end
            S_E2: begin
               case (opc)
                  OP_ST: begin
                     ARF_OutBSel = 2'b00;
                     RF_O1Sel    = sel_rd;
                     Mem_CS      = 1'b0;
                     Mem_WR      = 1'b1;
                  end
                  OP_MOV: begin
                     RF_O1Sel = sel_rs;
                     RF_RSel  = rd_oh;
                     zlat_we  = 1'b1;
                  end
                  default: begin
                     if (is_alu) begin
                        RF_O1Sel   = sel_rd;
                        RF_O2Sel   = sel_rs;
                        ALU_FunSel = alu_code;
                        RF_RSel    = rd_oh;
                        zlat_we    = 1'b1;
                     end
                  end
               endcase
            end
            S_HALT: begin
               Halted = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
